fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//   Instruction fetch sequencer for the byte-wide instruction ROM. Holds the PC,
//   reads the four bytes of each 32-bit instruction over four cycles through a
//   single byte port, and assembles them big-endian (byte at PC is bits [31:24]).
//   Presents the assembled word to decode with a valid/ready handshake and
//   accepts PC redirects from the branch/jump logic.
// PARAMETERS
//   ADDRESS_WIDTH  32  width of PC and byte address
//   DATA_WIDTH     8   ROM byte width; fixed at 8
//   INSTR_WIDTH    32  assembled instruction width; fixed at 4*DATA_WIDTH
//   RESET_PC       0   PC loaded on reset; must be word aligned
// PORTS
//   clk          in   1              clock, rising edge
//   rst          in   1              asynchronous reset, active high
//   byte_addr    out  ADDRESS_WIDTH  ROM byte address; ROM returns data combinationally
//   byte_data    in   DATA_WIDTH     ROM byte at byte_addr, same cycle
//   redirect     in   1              load redirect_pc as next fetch PC
//   redirect_pc  in   ADDRESS_WIDTH  target PC; bits [1:0] ignored (forced 0)
//   instr        out  INSTR_WIDTH    assembled instruction
//   instr_pc     out  ADDRESS_WIDTH  PC of instr
//   instr_valid  out  1              instr/instr_pc valid
//   instr_ready  in   1              decode accepts instr this cycle
//   busy         out  1              high while in FETCH
// BEHAVIOUR
//   State: pc (ADDRESS_WIDTH), cnt (2 bit), shreg (INSTR_WIDTH), FSM {FETCH, HOLD}.
//   Reset (async, any state): FSM=FETCH, pc=RESET_PC, cnt=0, shreg=0,
//     instr=0, instr_pc=RESET_PC, instr_valid=0. Partial fetch discarded.
//   byte_addr = pc + cnt (combinational, modulo 2^ADDRESS_WIDTH); in HOLD cnt=0.
//   FETCH: each edge shreg <= {shreg[23:0], byte_data}, cnt <= cnt+1.
//     On the edge with cnt==3: instr <= {shreg[23:0], byte_data}, instr_pc <= pc,
//     instr_valid <= 1, cnt wraps to 0, FSM -> HOLD.
//   Latency: instr_valid rises on the 4th edge after FETCH entry. Throughput
//     max one instruction per 5 cycles (4 FETCH + 1 HOLD with ready high).
//   HOLD: instr, instr_pc, instr_valid stable while instr_ready=0 (no limit).
//     Edge with instr_ready=1: transfer done; pc <= pc+4 (wraps modulo
//     2^ADDRESS_WIDTH), instr_valid <= 0, FSM -> FETCH.
//   instr_ready ignored while instr_valid=0.
//   Redirect (priority over everything except rst), any state, at edge:
//     pc <= {redirect_pc[ADDRESS_WIDTH-1:2],2'b00}, cnt <= 0, FSM -> FETCH,
//     instr_valid <= 0; partial bytes discarded.
//   redirect & instr_valid & instr_ready same edge: word counts as transferred
//     to decode; next fetch starts at redirect_pc (not pc+4).
//   redirect & instr_valid & !instr_ready: held word dropped, never transferred.
//   redirect on the cnt==3 FETCH edge: word not delivered, instr_valid stays 0.
//   busy = (FSM==FETCH). Unknown FSM encodings recover to FETCH.
// TESTING
//   ROM[0..3]=DE AD BE EF, ready=1 after rst -> 4th edge valid=1, instr=DEADBEEF, pc=0.
//   ROM[4..7]=00 11 22 33, ready=1 -> next word 00112233, instr_pc=4, 5-cycle gap.
//   ready=0 for 10 cycles in HOLD -> instr/instr_pc/valid unchanged; then accept, pc=4.
//   redirect=1, redirect_pc=0x0000_0013 at cnt==2 -> byte_addr=0x10 next cycle,
//     word from 0x10..0x13 delivered with instr_pc=0x10.
//   pc=0xFFFF_FFFC accepted -> next fetch byte_addr=0x0, instr_pc=0x0 (wrap).
//   rst asserted mid-FETCH (cnt=2) -> valid=0, byte_addr=RESET_PC immediately.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Purpose : instruction fetch sequencer; reads a 32-bit word as four bytes (big-endian) from a byte ROM.
// Latency : word valid on the 4th clock edge after entering FETCH; at most one word every 5 cycles.
// Backpressure: the word is held with instr_valid high for as long as instr_ready stays low.
//
// Ports:
//   clk, rst            rising-edge clock; asynchronous active-high reset
//   byte_addr/byte_data ROM byte address (pc + cnt) and its combinational read data
//   redirect/redirect_pc PC redirect; the target is word-aligned by dropping bits [1:0]
//   instr/instr_pc      assembled word and its PC, qualified by instr_valid
//   instr_valid/ready   handshake to decode
//   busy                high while the sequencer is fetching bytes
module fetch_ctrl #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 8,
    parameter int                         INSTR_WIDTH   = 4 * DATA_WIDTH,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDRESS_WIDTH-1:0] byte_addr,
    input  logic [DATA_WIDTH-1:0]    byte_data,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic [INSTR_WIDTH-1:0]   instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic                     busy
);

    // One-hot encoding so that corrupted values are distinguishable and recover to FETCH.
    localparam logic [1:0] ST_FETCH = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;

    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(4);

    logic [1:0]               state_q,    state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q,       pc_d;
    logic [1:0]               cnt_q,      cnt_d;
    logic [INSTR_WIDTH-1:0]   shreg_q,    shreg_d;
    logic [INSTR_WIDTH-1:0]   instr_q,    instr_d;
    logic [ADDRESS_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                     valid_q,    valid_d;

    // Shift in the current ROM byte; on the last byte this is the complete word.
    logic [INSTR_WIDTH-1:0]   shifted;
    assign shifted = {shreg_q[INSTR_WIDTH-DATA_WIDTH-1:0], byte_data};

    // cnt is zero outside FETCH, so byte_addr sits on pc while holding.
    assign byte_addr   = pc_q + {{(ADDRESS_WIDTH-2){1'b0}}, cnt_q};
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign busy        = (state_q == ST_FETCH);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;

        case (state_q)
            ST_FETCH: begin
                shreg_d = shifted;
                cnt_d   = cnt_q + 2'd1;
                // A redirect on the final byte suppresses delivery of the word.
                if (cnt_q == 2'd3 && !redirect) begin
                    instr_d    = shifted;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    pc_d    = pc_q + PC_STEP;
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                cnt_d   = 2'd0;
                valid_d = 1'b0;
                state_d = ST_FETCH;
            end
        endcase

        // Redirect wins over the normal sequence; a held word accepted on the same
        // edge still counts as delivered, but the next fetch starts at the target.
        if (redirect) begin
            pc_d    = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
            cnt_d   = 2'd0;
            valid_d = 1'b0;
            state_d = ST_FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            cnt_q      <= 2'd0;
            shreg_q    <= '0;
            instr_q    <= '0;
            instr_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

endmodule
